// File: rtl/mem_debug_bridge.sv
// Host-link debug bridge: decodes byte-serial W/R commands into single
// override-port memory accesses and returns ACK/NAK or read-data bytes.
module mem_debug_bridge #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        memControl,
  output logic        memRnW,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  input  logic [15:0] memDataOut,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = $clog2(READ_LATENCY + 2);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    MEM_WR,
    MEM_RD,
    TX_HI,
    TX_LO,
    TX_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      arg_cnt_q, arg_cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      rd_lo_q, rd_lo_d;
  logic [2:0]      arg_pos;
  logic            rx_fire;

  assign rxReady    = ~rst & ((state_q == IDLE) | (state_q == ARGS));
  assign rx_fire    = rxValid & rxReady;
  assign memControl = (state_q == MEM_WR) | (state_q == MEM_RD);
  assign memRnW     = (state_q != MEM_WR);
  assign memAddr    = addr_q;
  assign memDataIn  = wdata_q;
  assign txValid    = (state_q == TX_HI) | (state_q == TX_LO) | (state_q == TX_ACK);
  assign txData     = tx_data_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    arg_cnt_d = arg_cnt_q;
    is_wr_d   = is_wr_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    rd_lo_d   = rd_lo_q;
    // Reads skip the two data slots, so both opcodes share one byte-position map.
    arg_pos   = is_wr_q ? arg_cnt_q : arg_cnt_q + 3'd2;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          tmo_d = '0;
          if (rxData == OP_W) begin
            arg_cnt_d = 3'd4;
            is_wr_d   = 1'b1;
            state_d   = ARGS;
          end else if (rxData == OP_R) begin
            arg_cnt_d = 3'd2;
            is_wr_d   = 1'b0;
            state_d   = ARGS;
          end else begin
            tx_data_d = RSP_NAK;
            state_d   = TX_ACK;
          end
        end
      end
      ARGS: begin
        if (rx_fire) begin
          tmo_d     = '0;
          arg_cnt_d = arg_cnt_q - 3'd1;
          case (arg_pos)
            3'd4:    addr_d[15:8]  = rxData;
            3'd3:    addr_d[7:0]   = rxData;
            3'd2:    wdata_d[15:8] = rxData;
            3'd1:    wdata_d[7:0]  = rxData;
            default: ;
          endcase
          if (arg_cnt_q == 3'd1) begin
            lat_d   = '0;
            state_d = is_wr_q ? MEM_WR : MEM_RD;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      MEM_WR: begin
        tx_data_d = RSP_ACK;
        state_d   = TX_ACK;
      end
      MEM_RD: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          tx_data_d = memDataOut[15:8];
          rd_lo_d   = memDataOut[7:0];
          state_d   = TX_HI;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      TX_HI: begin
        if (txReady) begin
          tx_data_d = rd_lo_q;
          state_d   = TX_LO;
        end
      end
      TX_LO: begin
        if (txReady) state_d = IDLE;
      end
      TX_ACK: begin
        if (txReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      arg_cnt_q <= '0;
      is_wr_q   <= 1'b0;
      tmo_q     <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      rd_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      arg_cnt_q <= arg_cnt_d;
      is_wr_q   <= is_wr_d;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      rd_lo_q   <= rd_lo_d;
    end
  end

endmodule

// File: tb/tb_mem_debug_bridge.sv
// Bench for mem_debug_bridge: directed scenarios plus randomized commands
// checked against a command-level model of memory contents and responses.
module tb_mem_debug_bridge;

  localparam int unsigned RL  = 1;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b1;
  logic        memControl;
  logic        memRnW;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut = 16'h0000;
  logic        busy;

  always #5 clk = ~clk;

  mem_debug_bridge #(
    .READ_LATENCY(RL),
    .TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .memControl(memControl),
    .memRnW    (memRnW),
    .memAddr   (memAddr),
    .memDataIn (memDataIn),
    .memDataOut(memDataOut),
    .busy      (busy)
  );

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic        rnw;
    logic [15:0] a;
    logic [15:0] d;
  } acc_t;

  acc_t        mem_log[$];
  logic [7:0]  tx_q[$];
  logic [15:0] env_mem[logic [15:0]];
  logic [15:0] ref_mem[logic [15:0]];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Core memory stand-in and bus/link monitors; all sampling on the falling edge.
  always @(negedge clk) begin
    if (memControl) begin
      mem_log.push_back({memRnW, memAddr, memDataIn});
      if (!memRnW) env_mem[memAddr] = memDataIn;
    end
    memDataOut = env_rd(memAddr);
    if (txValid && txReady) tx_q.push_back(txData);
  end

  // Command-level model: response bytes and memory effect of one command.
  task automatic ref_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d,
                         output int n, output logic [7:0] r0, output logic [7:0] r1);
    logic [15:0] v;
    r1 = 8'h00;
    if (op == 8'h57) begin
      ref_mem[a] = d;
      n  = 1;
      r0 = 8'h06;
    end else if (op == 8'h52) begin
      v  = ref_rd(a);
      n  = 2;
      r0 = v[15:8];
      r1 = v[7:0];
    end else begin
      n  = 1;
      r0 = 8'h15;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rxData  = b;
    rxValid = 1'b1;
    n = 0;
    while (!rxReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL rx_accept: byte %h not accepted, rxReady=%b required 1", b, rxReady);
    end
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d,
                          input int gmax);
    logic [7:0] bytes[$];
    bytes.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
    end
    if (op == 8'h57) begin
      bytes.push_back(d[15:8]);
      bytes.push_back(d[7:0]);
    end
    foreach (bytes[i]) begin
      if (gmax > 0) repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      send_byte(bytes[i]);
    end
  endtask

  task automatic wait_tx(input int need, input bit rnd);
    int n;
    n = 0;
    while (tx_q.size() < need && n < 2000) begin
      if (rnd) txReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    txReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    mem_log.delete();
    tx_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (rxReady !== 1'b0) $display("FAIL rst_rxready: got %b want 0", rxReady); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (memControl !== 1'b0) $display("FAIL rst_memcontrol: got %b want 0", memControl); else passed++;
    total++; if (memRnW !== 1'b1) $display("FAIL rst_memrnw: got %b want 1", memRnW); else passed++;
    total++; if ({memAddr, memDataIn} !== 32'h0) $display("FAIL rst_addr_data: got %h want 0", {memAddr, memDataIn}); else passed++;
    total++; if ({txValid, txData} !== 9'h0) $display("FAIL rst_tx: got %h want 0", {txValid, txData}); else passed++;
    rst = 1'b0;
    #1;
    total++; if (rxReady !== 1'b1) $display("FAIL rst_release_rxready: got %b want 1", rxReady); else passed++;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_write();
    int n; logic [7:0] r0, r1;
    clear_logs();
    txReady = 1'b1;
    send_cmd(8'h57, 16'h0010, 16'hBEEF, 0);
    ref_cmd(8'h57, 16'h0010, 16'hBEEF, n, r0, r1);
    wait_tx(n, 1'b0);
    total++; if (tx_q.size() != 1 || tx_q[0] !== r0)
      $display("FAIL write_resp: got %0d bytes first %h want 1 byte %h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, r0);
    else passed++;
    total++; if (mem_log.size() != 1 || mem_log[0] !== {1'b0, 16'h0010, 16'hBEEF})
      $display("FAIL write_access: got %0d cycles first %h want 1 cycle %h", mem_log.size(), (mem_log.size() > 0) ? mem_log[0] : '1, {1'b0, 16'h0010, 16'hBEEF});
    else passed++;
    total++; if ({memAddr, memDataIn} !== {16'h0010, 16'hBEEF}) $display("FAIL write_hold: got %h want 0010beef", {memAddr, memDataIn}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL write_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_readback();
    int n; logic [7:0] r0, r1; bit ok;
    clear_logs();
    send_cmd(8'h52, 16'h0010, 16'h0000, 0);
    ref_cmd(8'h52, 16'h0010, 16'h0000, n, r0, r1);
    wait_tx(n, 1'b0);
    total++; if (tx_q.size() != 2 || tx_q[0] !== r0 || tx_q[1] !== r1)
      $display("FAIL readback_resp: got %0d bytes %h%h want %h%h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, (tx_q.size() > 1) ? tx_q[1] : 8'hxx, r0, r1);
    else passed++;
    ok = (mem_log.size() == RL + 1);
    foreach (mem_log[i]) if (mem_log[i].rnw !== 1'b1 || mem_log[i].a !== 16'h0010) ok = 1'b0;
    total++; if (ok !== 1'b1) $display("FAIL readback_access: got %0d read cycles want %0d at 0010", mem_log.size(), RL + 1); else passed++;
  endtask

  task automatic test_backpressure();
    int n, bad; logic [7:0] r0, r1;
    clear_logs();
    txReady = 1'b0;
    send_cmd(8'h52, 16'h0010, 16'h0000, 0);
    ref_cmd(8'h52, 16'h0010, 16'h0000, n, r0, r1);
    n = 0;
    while (!txValid && n < 50) begin @(posedge clk); #1; n++; end
    bad = 0;
    repeat (50) begin
      if (txValid !== 1'b1 || txData !== r0) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad != 0) $display("FAIL bp_stall: got %0d unstable cycles (last txValid=%b txData=%h) want 0 at %h", bad, txValid, txData, r0); else passed++;
    total++; if (mem_log.size() != RL + 1) $display("FAIL bp_no_extra_access: got %0d cycles want %0d", mem_log.size(), RL + 1); else passed++;
    txReady = 1'b1;
    wait_tx(2, 1'b0);
    total++; if (tx_q.size() != 2 || tx_q[0] !== r0 || tx_q[1] !== r1)
      $display("FAIL bp_resp: got %0d bytes want %h%h", tx_q.size(), r0, r1);
    else passed++;
  endtask

  task automatic test_bad_opcode();
    int n; logic [7:0] r0, r1;
    clear_logs();
    send_cmd(8'h41, 16'h0000, 16'h0000, 0);
    ref_cmd(8'h41, 16'h0000, 16'h0000, n, r0, r1);
    wait_tx(n, 1'b0);
    total++; if (tx_q.size() != 1 || tx_q[0] !== r0)
      $display("FAIL bad_op_resp: got %0d bytes first %h want %h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, r0);
    else passed++;
    total++; if (mem_log.size() != 0) $display("FAIL bad_op_access: got %0d cycles want 0", mem_log.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bad_op_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_timeout();
    int n; logic [7:0] r0, r1;
    clear_logs();
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) $display("FAIL timeout_early: got busy=%b want 1 after %0d idle cycles", busy, TMO - 1); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL timeout_expire: got busy=%b want 0 after %0d idle cycles", busy, TMO); else passed++;
    repeat (5) begin @(posedge clk); #1; end
    total++; if (tx_q.size() != 0 || mem_log.size() != 0)
      $display("FAIL timeout_silent: got %0d tx bytes %0d mem cycles want 0 0", tx_q.size(), mem_log.size());
    else passed++;
    send_cmd(8'h52, 16'h0000, 16'h0000, 0);
    ref_cmd(8'h52, 16'h0000, 16'h0000, n, r0, r1);
    wait_tx(n, 1'b0);
    total++; if (tx_q.size() != 2 || tx_q[0] !== r0 || tx_q[1] !== r1)
      $display("FAIL timeout_recover: got %0d bytes want %h%h", tx_q.size(), r0, r1);
    else passed++;
  endtask

  task automatic test_reset_mid_access();
    clear_logs();
    send_cmd(8'h52, 16'h1234, 16'h0000, 0);
    total++; if (memControl !== 1'b1) $display("FAIL mid_rd_active: got memControl=%b want 1", memControl); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({memControl, txValid} !== 2'b00) $display("FAIL mid_rd_reset: got memControl/txValid=%b want 00", {memControl, txValid}); else passed++;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (tx_q.size() != 0) $display("FAIL mid_rd_no_resp: got %0d tx bytes want 0", tx_q.size()); else passed++;
    total++; if (memAddr !== 16'h0000 || busy !== 1'b0) $display("FAIL mid_rd_state: got addr=%h busy=%b want 0000 0", memAddr, busy); else passed++;
  endtask

  task automatic test_random();
    int n, sel; logic [7:0] op, r0, r1; logic [15:0] a, d; bit ok;
    for (int i = 0; i < 40; i++) begin
      clear_logs();
      sel = $urandom_range(0, 9);
      if (sel < 4) op = 8'h57;
      else if (sel < 8) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'hFF;
      end
      sel = $urandom_range(0, 5);
      a = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'h0100 + 16'($urandom_range(0, 7));
      d = 16'($urandom_range(0, 65535));
      send_cmd(op, a, d, 4);
      ref_cmd(op, a, d, n, r0, r1);
      wait_tx(n, 1'b1);
      ok = (tx_q.size() == n) && (tx_q[0] === r0) && (n == 1 || tx_q[1] === r1);
      total++; if (!ok)
        $display("FAIL rand_resp[%0d]: op %h addr %h got %0d bytes %h want %0d bytes %h%h", i, op, a, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, n, r0, r1);
      else passed++;
      if (op == 8'h57) ok = (mem_log.size() == 1) && (mem_log[0] === {1'b0, a, d});
      else if (op == 8'h52) begin
        ok = (mem_log.size() == RL + 1);
        foreach (mem_log[k]) if (mem_log[k].rnw !== 1'b1 || mem_log[k].a !== a) ok = 1'b0;
      end else ok = (mem_log.size() == 0);
      total++; if (!ok)
        $display("FAIL rand_access[%0d]: op %h addr %h got %0d mem cycles (unexpected content or count)", i, op, a, mem_log.size());
      else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_backpressure();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
